// File: rtl/slurm16_cpu_alu_flags_if.sv
// rtl/slurm16_cpu_alu_flags_if.sv - operand, result and flag bundle between the pipeline and the ALU
interface slurm16_cpu_alu_flags_if;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [4:0]  aluOp;
  logic [15:0] aluOut;
  logic        C;
  logic        Z;
  logic        S;
  logic        V;
  logic        C_in;
  logic        Z_in;
  logic        S_in;
  logic        V_in;
  logic        load_flags;

  modport master (
    output aluA, aluB, aluOp, C_in, Z_in, S_in, V_in, load_flags,
    input  aluOut, C, Z, S, V
  );

  modport slave (
    input  aluA, aluB, aluOp, C_in, Z_in, S_in, V_in, load_flags,
    output aluOut, C, Z, S, V
  );
endinterface

// File: rtl/slurm16_cpu_alu_flags.sv
// rtl/slurm16_cpu_alu_flags.sv - 16-bit ALU with registered result and C/Z/S/V flag file
module slurm16_cpu_alu_flags (
  input  logic                    CLK,
  input  logic                    RSTb,
  slurm16_cpu_alu_flags_if.slave  alu
);
  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_ADC   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_SBB   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_MUL   = 5'd8;
  localparam logic [4:0] OP_UMULU = 5'd9;
  localparam logic [4:0] OP_SMULU = 5'd10;
  localparam logic [4:0] OP_CMP   = 5'd11;
  localparam logic [4:0] OP_TEST  = 5'd12;
  localparam logic [4:0] OP_BSWAP = 5'd13;
  localparam logic [4:0] OP_ASR   = 5'd14;
  localparam logic [4:0] OP_LSR   = 5'd15;
  localparam logic [4:0] OP_LSL   = 5'd16;
  localparam logic [4:0] OP_ROLC  = 5'd17;
  localparam logic [4:0] OP_RORC  = 5'd18;
  localparam logic [4:0] OP_ROL   = 5'd19;
  localparam logic [4:0] OP_ROR   = 5'd20;
  localparam logic [4:0] OP_CC    = 5'd21;
  localparam logic [4:0] OP_SC    = 5'd22;
  localparam logic [4:0] OP_CZ    = 5'd23;
  localparam logic [4:0] OP_SZ    = 5'd24;
  localparam logic [4:0] OP_CS    = 5'd25;
  localparam logic [4:0] OP_SS    = 5'd26;

  logic [15:0] a, b;
  logic [4:0]  op;
  logic        cin, bin;
  logic [16:0] sum, diff;
  logic [31:0] uprod, sprod;
  logic [15:0] r, res;
  logic        upd_zs;
  logic        n_c, n_z, n_s, n_v;

  assign a  = alu.aluA;
  assign b  = alu.aluB;
  assign op = alu.aluOp;

  // Carry chains use the flag registered on the previous edge, so ADC/SBB chain back to back.
  assign cin  = (op == OP_ADC) & alu.C;
  assign bin  = (op == OP_SBB) & alu.C;
  assign sum  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {16'b0, bin};

  assign uprod = {16'b0, a} * {16'b0, b};
  assign sprod = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});

  always_comb begin
    r      = a;
    upd_zs = 1'b0;
    n_c    = alu.C;
    n_z    = alu.Z;
    n_s    = alu.S;
    n_v    = alu.V;
    case (op)
      OP_MOV: r = b;
      OP_ADD, OP_ADC: begin
        r      = sum[15:0];
        n_c    = sum[16];
        n_v    = (a[15] == b[15]) && (sum[15] != a[15]);
        upd_zs = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        r      = diff[15:0];
        n_c    = diff[16];
        n_v    = (a[15] != b[15]) && (diff[15] != a[15]);
        upd_zs = 1'b1;
      end
      OP_AND, OP_TEST: begin r = a & b; upd_zs = 1'b1; end
      OP_OR:           begin r = a | b; upd_zs = 1'b1; end
      OP_XOR:          begin r = a ^ b; upd_zs = 1'b1; end
      // Low half of a product is identical for signed and unsigned operands.
      OP_MUL:          begin r = sprod[15:0];   upd_zs = 1'b1; end
      OP_UMULU:        begin r = uprod[31:16];  upd_zs = 1'b1; end
      OP_SMULU:        begin r = sprod[31:16];  upd_zs = 1'b1; end
      OP_BSWAP:        begin r = {a[7:0], a[15:8]}; upd_zs = 1'b1; end
      OP_ASR:  begin r = {a[15], a[15:1]};  n_c = a[0];  upd_zs = 1'b1; end
      OP_LSR:  begin r = {1'b0, a[15:1]};   n_c = a[0];  upd_zs = 1'b1; end
      OP_LSL:  begin r = {a[14:0], 1'b0};   n_c = a[15]; upd_zs = 1'b1; end
      OP_ROLC: begin r = {a[14:0], alu.C};  n_c = a[15]; upd_zs = 1'b1; end
      OP_RORC: begin r = {alu.C, a[15:1]};  n_c = a[0];  upd_zs = 1'b1; end
      OP_ROL:  begin r = {a[14:0], a[15]};  upd_zs = 1'b1; end
      OP_ROR:  begin r = {a[0], a[15:1]};   upd_zs = 1'b1; end
      OP_CC:   n_c = 1'b0;
      OP_SC:   n_c = 1'b1;
      OP_CZ:   n_z = 1'b0;
      OP_SZ:   n_z = 1'b1;
      OP_CS:   n_s = 1'b0;
      OP_SS:   n_s = 1'b1;
      default: r = a;
    endcase
    if (upd_zs) begin
      n_z = (r == 16'h0000);
      n_s = r[15];
    end
    // Compare and test only set flags; the result port passes A through.
    res = (op == OP_CMP || op == OP_TEST) ? a : r;
  end

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      alu.aluOut <= 16'h0000;
      alu.C      <= 1'b0;
      alu.Z      <= 1'b0;
      alu.S      <= 1'b0;
      alu.V      <= 1'b0;
    end else begin
      alu.aluOut <= res;
      if (alu.load_flags) begin
        alu.C <= alu.C_in;
        alu.Z <= alu.Z_in;
        alu.S <= alu.S_in;
        alu.V <= alu.V_in;
      end else begin
        alu.C <= n_c;
        alu.Z <= n_z;
        alu.S <= n_s;
        alu.V <= n_v;
      end
    end
  end
endmodule

// File: tb/tb_slurm16_cpu_alu_flags.sv
// tb/tb_slurm16_cpu_alu_flags.sv - self-checking bench for slurm16_cpu_alu_flags
module tb_slurm16_cpu_alu_flags;
  logic CLK;
  logic RSTb;
  slurm16_cpu_alu_flags_if bus();

  slurm16_cpu_alu_flags dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .alu  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int mout;
  bit mc, mz, ms, mv;

  typedef struct {
    int          op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  f;
  } vec_t;

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive one operation, clock it, and advance the reference model from the op table.
  task automatic step(input bit rst, input bit ld, input int op,
                      input logic [15:0] a, input logic [15:0] b, input logic [3:0] fin);
    int ai, bi, r, full, sr, ci;
    longint p;
    bit nc, nz, ns, nv, zs;
    RSTb           = rst;
    bus.load_flags = ld;
    bus.aluOp      = 5'(op);
    bus.aluA       = a;
    bus.aluB       = b;
    {bus.C_in, bus.Z_in, bus.S_in, bus.V_in} = fin;
    @(posedge CLK);
    #1;
    ai = int'(a); bi = int'(b); r = ai;
    nc = mc; nz = mz; ns = ms; nv = mv; zs = 0;
    case (op)
      0: r = bi;
      1, 2: begin
        ci = (op == 2) ? int'(mc) : 0;
        full = ai + bi + ci;
        r = full % 65536; nc = (full > 65535);
        sr = sx(ai) + sx(bi) + ci; nv = (sr > 32767) || (sr < -32768); zs = 1;
      end
      3, 4, 11: begin
        ci = (op == 4) ? int'(mc) : 0;
        full = ai - bi - ci;
        r = (full + 65536) % 65536; nc = (full < 0);
        sr = sx(ai) - sx(bi) - ci; nv = (sr > 32767) || (sr < -32768); zs = 1;
      end
      5, 12: begin r = ai & bi; zs = 1; end
      6:  begin r = ai | bi; zs = 1; end
      7:  begin r = ai ^ bi; zs = 1; end
      8:  begin r = int'((longint'(ai) * longint'(bi)) % 65536); zs = 1; end
      9:  begin r = int'((longint'(ai) * longint'(bi)) / 65536); zs = 1; end
      10: begin p = longint'(sx(ai)) * longint'(sx(bi)); r = int'((p >>> 16) & 65535); zs = 1; end
      13: begin r = (ai % 256) * 256 + ai / 256; zs = 1; end
      14: begin r = ai / 2 + ((ai >= 32768) ? 32768 : 0); nc = (ai % 2 == 1); zs = 1; end
      15: begin r = ai / 2; nc = (ai % 2 == 1); zs = 1; end
      16: begin r = (ai * 2) % 65536; nc = (ai >= 32768); zs = 1; end
      17: begin r = (ai * 2) % 65536 + int'(mc); nc = (ai >= 32768); zs = 1; end
      18: begin r = ai / 2 + int'(mc) * 32768; nc = (ai % 2 == 1); zs = 1; end
      19: begin r = (ai * 2) % 65536 + ai / 32768; zs = 1; end
      20: begin r = ai / 2 + (ai % 2) * 32768; zs = 1; end
      21: nc = 0;
      22: nc = 1;
      23: nz = 0;
      24: nz = 1;
      25: ns = 0;
      26: ns = 1;
      default: ;
    endcase
    if (zs) begin nz = (r == 0); ns = (r >= 32768); end
    if (rst) begin
      mout = 0; mc = 0; mz = 0; ms = 0; mv = 0;
    end else begin
      mout = (op == 11 || op == 12) ? ai : r;
      if (ld) {mc, mz, ms, mv} = fin;
      else    {mc, mz, ms, mv} = {nc, nz, ns, nv};
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1, 16'hFFFF, 16'h0001, 4'h0);
      total++;
      if (bus.aluOut !== 16'h0000 || {bus.C, bus.Z, bus.S, bus.V} !== 4'b0000) begin
        bad++;
        $display("FAIL reset[%0d]: got out=%h CZSV=%b, want out=0000 CZSV=0000",
                 i, bus.aluOut, {bus.C, bus.Z, bus.S, bus.V});
      end
    end
  endtask

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{1,  16'h0003, 16'h0007, 16'h000A, 4'b0000};
    v[1] = '{1,  16'hFFFF, 16'h0001, 16'h0000, 4'b1100};
    v[2] = '{1,  16'h7FFF, 16'h0001, 16'h8000, 4'b0011};
    v[3] = '{2,  16'h0000, 16'h0000, 16'h0000, 4'b0100};
    v[4] = '{3,  16'h0005, 16'h0007, 16'hFFFE, 4'b1010};
    v[5] = '{11, 16'h0009, 16'h0009, 16'h0009, 4'b0100};
    v[6] = '{16, 16'h8001, 16'h0000, 16'h0002, 4'b1000};
    v[7] = '{20, 16'h8001, 16'h0000, 16'hC000, 4'b1010};
    v[8] = '{14, 16'h8001, 16'h0000, 16'hC000, 4'b1010};
    v[9] = '{13, 16'h1234, 16'h0000, 16'h3412, 4'b1000};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, v[i].op, v[i].a, v[i].b, 4'h0);
      total++;
      if (bus.aluOut !== v[i].out || {bus.C, bus.Z, bus.S, bus.V} !== v[i].f) begin
        bad++;
        $display("FAIL directed[%0d] op=%0d: got out=%h CZSV=%b, want out=%h CZSV=%b",
                 i, v[i].op, bus.aluOut, {bus.C, bus.Z, bus.S, bus.V}, v[i].out, v[i].f);
      end
    end
  endtask

  task automatic test_flag_restore();
    step(1'b0, 1'b1, 1, 16'h0000, 16'h0000, 4'b1010);
    total++;
    if (bus.aluOut !== 16'h0000 || {bus.C, bus.Z, bus.S, bus.V} !== 4'b1010) begin
      bad++;
      $display("FAIL flag_restore: got out=%h CZSV=%b, want out=0000 CZSV=1010",
               bus.aluOut, {bus.C, bus.Z, bus.S, bus.V});
    end
    step(1'b1, 1'b1, 1, 16'h1234, 16'h0001, 4'b1111);
    total++;
    if (bus.aluOut !== 16'h0000 || {bus.C, bus.Z, bus.S, bus.V} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_over_load: got out=%h CZSV=%b, want out=0000 CZSV=0000",
               bus.aluOut, {bus.C, bus.Z, bus.S, bus.V});
    end
  endtask

  task automatic test_back_to_back();
    int ops[4] = '{2, 4, 17, 18};
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'b0, ops[$urandom_range(0, 3)], pick(), pick(), 4'h0);
      total++;
      if (bus.aluOut !== 16'(mout) || {bus.C, bus.Z, bus.S, bus.V} !== {mc, mz, ms, mv}) begin
        bad++;
        $display("FAIL back_to_back[%0d] op=%0d: got out=%h CZSV=%b, want out=%h CZSV=%b",
                 i, bus.aluOp, bus.aluOut, {bus.C, bus.Z, bus.S, bus.V}, 16'(mout), {mc, mz, ms, mv});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 31)), pick(), pick(), 4'($urandom));
      total++;
      if (bus.aluOut !== 16'(mout) || {bus.C, bus.Z, bus.S, bus.V} !== {mc, mz, ms, mv}) begin
        bad++;
        $display("FAIL random[%0d] op=%0d: got out=%h CZSV=%b, want out=%h CZSV=%b",
                 i, bus.aluOp, bus.aluOut, {bus.C, bus.Z, bus.S, bus.V}, 16'(mout), {mc, mz, ms, mv});
      end
    end
  endtask

  initial begin
    RSTb           = 1'b1;
    bus.load_flags = 1'b0;
    bus.aluOp      = 5'd0;
    bus.aluA       = 16'h0000;
    bus.aluB       = 16'h0000;
    {bus.C_in, bus.Z_in, bus.S_in, bus.V_in} = 4'h0;
    mout = 0; mc = 0; mz = 0; ms = 0; mv = 0;
    test_reset();
    test_directed();
    test_flag_restore();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
